// File: rtl/pcie_bar_resp_pkg.sv
// Shared definitions for the PCIe BAR0 Avalon-MM responder.
// The register word map, the control FSM states, the fill value for
// out-of-range reads, and a byte-lane merge helper.
package pcie_bar_resp_pkg;

  // Word indices of the register block; RAM starts at RAM_BASE.
  localparam int REG_ID         = 0;
  localparam int REG_SCRATCH    = 1;
  localparam int REG_DOORBELL   = 2;
  localparam int REG_IRQ_STATUS = 3;
  localparam int REG_RD_COUNT   = 4;
  localparam int REG_WR_COUNT   = 5;
  localparam int RAM_BASE       = 8;

  localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_BURST
  } state_t;

  // Replace the byte lanes of old_word selected by be with new_word's lanes.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/pcie_bar_resp_ram.sv
// Byte-enabled single-port scratch RAM with one-cycle registered read.
// Read-during-write returns the old word; the responder never relies on it.
module pcie_bar_resp_ram #(
  parameter int unsigned WORDS = 56,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Byte-lane write and registered read on the shared address.
  // NOTE: the array has no reset so it maps onto block RAM; its contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pcie_bar_avmm_responder.sv
// Avalon-MM slave behind the PCIe HIP BAR0 Rxm master: ID/scratch/doorbell
// registers, read/write word counters and a scratch RAM, with fixed
// two-cycle read latency and a level doorbell interrupt.
// Optional build macro PCIE_BAR_RESP_BURST_EN adds avs_burstcount and
// read/write burst support.
module pcie_bar_avmm_responder
  import pcie_bar_resp_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] ID_VALUE = 32'hC0DE_0001
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
`ifdef PCIE_BAR_RESP_BURST_EN
  input  logic [6:0]        avs_burstcount,
`endif
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              irq
);

  localparam int unsigned RAM_WORDS = (DEPTH > RAM_BASE) ? DEPTH - RAM_BASE : 1;
  localparam int unsigned RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  function automatic logic is_ram(input logic [ADDR_W-1:0] a);
    return in_range(a) && (a >= ADDR_W'(RAM_BASE));
  endfunction

  function automatic logic [RAM_AW-1:0] ram_index(input logic [ADDR_W-1:0] a);
    return RAM_AW'(a - ADDR_W'(RAM_BASE));
  endfunction

  state_t            state_q, state_d;
  logic              rd_issue, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [31:0]       scratch_q, rd_count_q, wr_count_q;
  logic              irq_pending_q;
  logic [31:0]       rd_reg_data, reg_data1_q, ram_rdata;
  logic              rd_v1_q, ram_sel1_q;

`ifdef PCIE_BAR_RESP_BURST_EN
  logic [6:0]        burst_len, rd_left_q, wr_left_q;
  logic [ADDR_W-1:0] rd_next_q, wr_next_q;

  assign burst_len = (avs_burstcount == 7'd0) ? 7'd1 : avs_burstcount;
`endif

  // Control state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= ST_INIT;
    else                state_q <= state_d;
  end

  // Next state, stall, and the single internal read/write issue per cycle.
  // NOTE: every output is defaulted first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d         = state_q;
    avs_waitrequest = 1'b1;
    rd_issue        = 1'b0;
    rd_addr         = avs_address;
    wr_en           = 1'b0;
    wr_addr         = avs_address;
    unique case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        avs_waitrequest = 1'b0;
        wr_en           = avs_write;
        // A simultaneous read is dropped in favour of the write.
        rd_issue        = avs_read & ~avs_write;
`ifdef PCIE_BAR_RESP_BURST_EN
        if (wr_left_q != 7'd0) wr_addr = wr_next_q;
        if (avs_read & ~avs_write) state_d = ST_RD_BURST;
`endif
      end
`ifdef PCIE_BAR_RESP_BURST_EN
      ST_RD_BURST: begin
        if (rd_left_q != 7'd0) begin
          rd_issue = 1'b1;
          rd_addr  = rd_next_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_INIT;
    endcase
  end

`ifdef PCIE_BAR_RESP_BURST_EN
  // Burst address/length trackers for read issue and write beats.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_left_q <= '0;
      rd_next_q <= '0;
      wr_left_q <= '0;
      wr_next_q <= '0;
    end else begin
      if (state_q == ST_IDLE && rd_issue) begin
        rd_left_q <= burst_len - 7'd1;
        rd_next_q <= avs_address + ADDR_W'(1);
      end else if (state_q == ST_RD_BURST && rd_issue) begin
        rd_left_q <= rd_left_q - 7'd1;
        rd_next_q <= rd_next_q + ADDR_W'(1);
      end
      if (wr_en) begin
        if (wr_left_q != 7'd0) begin
          wr_left_q <= wr_left_q - 7'd1;
          wr_next_q <= wr_next_q + ADDR_W'(1);
        end else begin
          wr_left_q <= burst_len - 7'd1;
          wr_next_q <= avs_address + ADDR_W'(1);
        end
      end
    end
  end
`endif

  // Register writes, doorbell set/clear and the word counters.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scratch_q     <= '0;
      irq_pending_q <= 1'b0;
      rd_count_q    <= '0;
      wr_count_q    <= '0;
    end else begin
      if (wr_en) begin
        wr_count_q <= wr_count_q + 32'd1;
        case (wr_addr)
          ADDR_W'(REG_SCRATCH):
            scratch_q <= be_merge(scratch_q, avs_writedata, avs_byteenable);
          ADDR_W'(REG_DOORBELL):
            if (avs_byteenable[0] && avs_writedata[0]) irq_pending_q <= 1'b1;
          ADDR_W'(REG_IRQ_STATUS):
            if (avs_byteenable[0] && avs_writedata[0]) irq_pending_q <= 1'b0;
          default: ;
        endcase
      end
      if (rd_issue) rd_count_q <= rd_count_q + 32'd1;
    end
  end

  assign irq = irq_pending_q;

  // Register-side read data, captured alongside the RAM read so counters
  // report their value before this read's own increment.
  always_comb begin
    rd_reg_data = '0;
    if (!in_range(rd_addr)) begin
      rd_reg_data = BAD_ADDR_DATA;
    end else begin
      case (rd_addr)
        ADDR_W'(REG_ID):         rd_reg_data = ID_VALUE;
        ADDR_W'(REG_SCRATCH):    rd_reg_data = scratch_q;
        ADDR_W'(REG_IRQ_STATUS): rd_reg_data = {31'b0, irq_pending_q};
        ADDR_W'(REG_RD_COUNT):   rd_reg_data = rd_count_q;
        ADDR_W'(REG_WR_COUNT):   rd_reg_data = wr_count_q;
        default:                 rd_reg_data = '0;
      endcase
    end
  end

  pcie_bar_resp_ram #(
    .WORDS (RAM_WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk_clk),
    .addr  (wr_en ? ram_index(wr_addr) : ram_index(rd_addr)),
    .we    (wr_en && is_ram(wr_addr)),
    .be    (avs_byteenable),
    .wdata (avs_writedata),
    .rdata (ram_rdata)
  );

  // Two-stage read return: stage 1 alongside the RAM read, stage 2 output mux.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_v1_q           <= 1'b0;
      ram_sel1_q        <= 1'b0;
      reg_data1_q       <= '0;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
    end else begin
      rd_v1_q           <= rd_issue;
      ram_sel1_q        <= is_ram(rd_addr);
      reg_data1_q       <= rd_reg_data;
      avs_readdatavalid <= rd_v1_q;
      if (rd_v1_q) avs_readdata <= ram_sel1_q ? ram_rdata : reg_data1_q;
    end
  end

endmodule

// File: tb/tb_pcie_bar_avmm_responder.sv
// Directed bench for pcie_bar_avmm_responder: reset, register map, doorbell,
// pipelined RAM reads, out-of-range/RO writes, read/write collision, reset
// flush, and (with PCIE_BAR_RESP_BURST_EN) read/write bursts.
module tb_pcie_bar_avmm_responder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 64;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
`ifdef PCIE_BAR_RESP_BURST_EN
  logic [6:0]        avs_burstcount;
`endif
  logic              avs_waitrequest;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic              irq;

  int tests = 0;
  int fails = 0;

  always #5 clk_clk = ~clk_clk;

  pcie_bar_avmm_responder #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .ID_VALUE (32'hC0DE_0001)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
`ifdef PCIE_BAR_RESP_BURST_EN
    .avs_burstcount    (avs_burstcount),
`endif
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq               (irq)
  );

  // ---------------- bus helpers (no comparisons except wait timeouts) ----

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic bus_idle();
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_address    = '0;
    avs_writedata  = '0;
    avs_byteenable = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (avs_waitrequest && n < 20) begin
      step();
      n++;
    end
    if (avs_waitrequest) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: waitrequest=%0b after %0d cycles, need 0", avs_waitrequest, n);
    end
  endtask

  task automatic apply_reset();
    reset_reset_n = 1'b0;
    bus_idle();
    step();
    step();
    reset_reset_n = 1'b1;
    step();
  endtask

  task automatic wr_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                         input logic [3:0] be);
    wait_ready();
    avs_write      = 1'b1;
    avs_address    = addr;
    avs_writedata  = data;
    avs_byteenable = be;
    step();
    bus_idle();
  endtask

  // Issue one read; lat is the cycle (relative to acceptance) of readdatavalid.
  task automatic rd_word(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                         output int lat);
    wait_ready();
    avs_read    = 1'b1;
    avs_address = addr;
    step();
    bus_idle();
    lat = 1;
    while (!avs_readdatavalid && lat < 10) begin
      step();
      lat++;
    end
    data = avs_readdata;
  endtask

  // ---------------- scenarios ----------------

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    reset_reset_n = 1'b0;
    bus_idle();
    step();
    step();
    tests++;
    if (avs_waitrequest !== 1'b1) begin
      fails++; $display("FAIL rst_waitrequest: got %b, need 1", avs_waitrequest);
    end
    tests++;
    if (avs_readdatavalid !== 1'b0) begin
      fails++; $display("FAIL rst_readdatavalid: got %b, need 0", avs_readdatavalid);
    end
    tests++;
    if (avs_readdata !== 32'h0) begin
      fails++; $display("FAIL rst_readdata: got %h, need 00000000", avs_readdata);
    end
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL rst_irq: got %b, need 0", irq);
    end
    reset_reset_n = 1'b1;
    #1;
    tests++;
    if (avs_waitrequest !== 1'b1) begin
      fails++; $display("FAIL init_waitrequest: got %b, need 1", avs_waitrequest);
    end
    step();
    tests++;
    if (avs_waitrequest !== 1'b0) begin
      fails++; $display("FAIL idle_waitrequest: got %b, need 0", avs_waitrequest);
    end
    rd_word(ADDR_W'(0), d, lat);
    tests++;
    if (lat !== 2) begin
      fails++; $display("FAIL id_latency: got %0d, need 2", lat);
    end
    tests++;
    if (d !== 32'hC0DE_0001) begin
      fails++; $display("FAIL id_data: got %h, need c0de0001", d);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    int lat;
    rd_word(ADDR_W'(1), d, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL scratch_reset: got %h, need 00000000", d);
    end
    wr_word(ADDR_W'(1), 32'h1234_5678, 4'b0101);
    rd_word(ADDR_W'(1), d, lat);
    tests++;
    if (d !== 32'h0034_0078) begin
      fails++; $display("FAIL scratch_be0101: got %h, need 00340078", d);
    end
    rd_word(ADDR_W'(5), d, lat);
    tests++;
    if (d !== 32'd1) begin
      fails++; $display("FAIL wr_count_one: got %h, need 00000001", d);
    end
    wr_word(ADDR_W'(1), 32'hAABB_CCDD, 4'b1010);
    rd_word(ADDR_W'(1), d, lat);
    tests++;
    if (d !== 32'hAA34_CC78) begin
      fails++; $display("FAIL scratch_be1010: got %h, need aa34cc78", d);
    end
  endtask

  task automatic test_doorbell();
    logic [31:0] d;
    int lat;
    wr_word(ADDR_W'(2), 32'h1, 4'b1110);
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL db_be0_off: got irq %b, need 0", irq);
    end
    wr_word(ADDR_W'(2), 32'h2, 4'hF);
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL db_wd0_off: got irq %b, need 0", irq);
    end
    wr_word(ADDR_W'(2), 32'h1, 4'b0001);
    tests++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL db_set_next_cycle: got irq %b, need 1", irq);
    end
    rd_word(ADDR_W'(2), d, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL db_read_zero: got %h, need 00000000", d);
    end
    rd_word(ADDR_W'(3), d, lat);
    tests++;
    if (d !== 32'h1) begin
      fails++; $display("FAIL irq_status_set: got %h, need 00000001", d);
    end
    wr_word(ADDR_W'(3), 32'h1, 4'hF);
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL irq_clear: got irq %b, need 0", irq);
    end
    // Set then clear in consecutive cycles.
    avs_write = 1'b1; avs_address = ADDR_W'(2); avs_writedata = 32'h1; avs_byteenable = 4'hF;
    step();
    tests++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL b2b_set: got irq %b, need 1", irq);
    end
    avs_address = ADDR_W'(3);
    step();
    bus_idle();
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL b2b_set_clear: got irq %b, need 0", irq);
    end
    // Clear then set in consecutive cycles.
    avs_write = 1'b1; avs_address = ADDR_W'(3); avs_writedata = 32'h1; avs_byteenable = 4'hF;
    step();
    avs_address = ADDR_W'(2);
    step();
    bus_idle();
    tests++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL b2b_clear_set: got irq %b, need 1", irq);
    end
    wr_word(ADDR_W'(3), 32'h1, 4'h1);
  endtask

  task automatic test_ram_back_to_back();
    logic [31:0] sdata [8];
    logic        svalid [8];
    logic [31:0] d;
    int lat;
    logic exp_v;
    apply_reset();
    for (int i = 0; i < 4; i++) wr_word(ADDR_W'(8 + i), 32'hA0 + i, 4'hF);
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        avs_read    = 1'b1;
        avs_address = ADDR_W'(8 + c);
      end else begin
        bus_idle();
      end
      step();
      svalid[c] = avs_readdatavalid;
      sdata[c]  = avs_readdata;
    end
    for (int c = 0; c < 8; c++) begin
      exp_v = (c >= 1 && c <= 4);
      tests++;
      if (svalid[c] !== exp_v) begin
        fails++; $display("FAIL b2b_valid[%0d]: got %b, need %b", c, svalid[c], exp_v);
      end
      if (exp_v) begin
        tests++;
        if (sdata[c] !== 32'hA0 + c - 1) begin
          fails++; $display("FAIL b2b_data[%0d]: got %h, need %h", c, sdata[c], 32'hA0 + c - 1);
        end
      end
    end
    rd_word(ADDR_W'(4), d, lat);
    tests++;
    if (d !== 32'd4) begin
      fails++; $display("FAIL rd_count_four: got %h, need 00000004", d);
    end
    rd_word(ADDR_W'(5), d, lat);
    tests++;
    if (d !== 32'd4) begin
      fails++; $display("FAIL wr_count_four: got %h, need 00000004", d);
    end
  endtask

  task automatic test_write_then_read();
    int n = 0;
    wait_ready();
    avs_write = 1'b1; avs_address = ADDR_W'(20); avs_writedata = 32'h5555_AAAA; avs_byteenable = 4'hF;
    step();
    avs_write = 1'b0; avs_read = 1'b1;
    step();
    bus_idle();
    while (!avs_readdatavalid && n < 10) begin
      step();
      n++;
    end
    tests++;
    if (n !== 1) begin
      fails++; $display("FAIL wr_rd_latency: got %0d extra cycles, need 1", n);
    end
    tests++;
    if (avs_readdata !== 32'h5555_AAAA) begin
      fails++; $display("FAIL wr_rd_next_cycle: got %h, need 5555aaaa", avs_readdata);
    end
  endtask

  task automatic test_bad_addr();
    logic [31:0] d;
    int lat;
    rd_word(ADDR_W'(DEPTH), d, lat);
    tests++;
    if (d !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL bad_rd_depth: got %h, need deadbeef", d);
    end
    rd_word(ADDR_W'(255), d, lat);
    tests++;
    if (d !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL bad_rd_255: got %h, need deadbeef", d);
    end
    rd_word(ADDR_W'(6), d, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL reserved_rd: got %h, need 00000000", d);
    end
    wr_word(ADDR_W'(63), 32'h6363_6363, 4'hF);
    wr_word(ADDR_W'(DEPTH), 32'h1111_1111, 4'hF);
    wr_word(ADDR_W'(255), 32'h2222_2222, 4'hF);
    wr_word(ADDR_W'(0), 32'h3333_3333, 4'hF);
    wr_word(ADDR_W'(7), 32'h4444_4444, 4'hF);
    rd_word(ADDR_W'(63), d, lat);
    tests++;
    if (d !== 32'h6363_6363) begin
      fails++; $display("FAIL last_ram_word: got %h, need 63636363", d);
    end
    rd_word(ADDR_W'(8), d, lat);
    tests++;
    if (d !== 32'hA0) begin
      fails++; $display("FAIL ram8_untouched: got %h, need 000000a0", d);
    end
    rd_word(ADDR_W'(0), d, lat);
    tests++;
    if (d !== 32'hC0DE_0001) begin
      fails++; $display("FAIL id_ro: got %h, need c0de0001", d);
    end
    rd_word(ADDR_W'(7), d, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL reserved_ro: got %h, need 00000000", d);
    end
    // 4 preload + word 20 + words 63, 64, 255, 0, 7 since the last reset.
    rd_word(ADDR_W'(5), d, lat);
    tests++;
    if (d !== 32'd10) begin
      fails++; $display("FAIL wr_count_dropped: got %h, need 0000000a", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    int lat;
    int seen = 0;
    apply_reset();
    avs_read = 1'b1; avs_write = 1'b1; avs_address = ADDR_W'(1);
    avs_writedata = 32'hCAFE_F00D; avs_byteenable = 4'hF;
    step();
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      if (avs_readdatavalid) seen++;
      step();
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL collide_no_valid: got %0d beats, need 0", seen);
    end
    rd_word(ADDR_W'(4), d, lat);
    tests++;
    if (d !== 32'd0) begin
      fails++; $display("FAIL collide_rd_count: got %h, need 00000000", d);
    end
    rd_word(ADDR_W'(5), d, lat);
    tests++;
    if (d !== 32'd1) begin
      fails++; $display("FAIL collide_wr_count: got %h, need 00000001", d);
    end
    rd_word(ADDR_W'(1), d, lat);
    tests++;
    if (d !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL collide_write_done: got %h, need cafef00d", d);
    end
  endtask

  task automatic test_reset_flush();
    logic [31:0] d;
    int lat;
    int seen = 0;
    wait_ready();
    avs_read = 1'b1; avs_address = ADDR_W'(0);
    step();
    bus_idle();
    reset_reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (avs_readdatavalid) seen++;
      step();
    end
    reset_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (avs_readdatavalid) seen++;
      step();
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL flush_no_valid: got %0d beats, need 0", seen);
    end
    rd_word(ADDR_W'(4), d, lat);
    tests++;
    if (d !== 32'd0) begin
      fails++; $display("FAIL flush_rd_count: got %h, need 00000000", d);
    end
  endtask

`ifdef PCIE_BAR_RESP_BURST_EN
  task automatic test_burst();
    logic [31:0] sdata [7];
    logic        svalid [7];
    logic        swait [7];
    logic [31:0] d;
    int lat;
    logic exp_v, exp_w;
    apply_reset();
    avs_burstcount = 7'd1;
    for (int i = 0; i < 3; i++) wr_word(ADDR_W'(8 + i), 32'hA0 + i, 4'hF);
    wait_ready();
    avs_read = 1'b1; avs_address = ADDR_W'(8); avs_burstcount = 7'd3;
    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 0) begin
        bus_idle();
        avs_burstcount = 7'd1;
      end
      swait[c]  = avs_waitrequest;
      svalid[c] = avs_readdatavalid;
      sdata[c]  = avs_readdata;
    end
    for (int c = 0; c < 7; c++) begin
      exp_w = (c <= 2);
      exp_v = (c >= 1 && c <= 3);
      tests++;
      if (swait[c] !== exp_w) begin
        fails++; $display("FAIL burst_wait[%0d]: got %b, need %b", c, swait[c], exp_w);
      end
      tests++;
      if (svalid[c] !== exp_v) begin
        fails++; $display("FAIL burst_valid[%0d]: got %b, need %b", c, svalid[c], exp_v);
      end
      if (exp_v) begin
        tests++;
        if (sdata[c] !== 32'hA0 + c - 1) begin
          fails++; $display("FAIL burst_data[%0d]: got %h, need %h", c, sdata[c], 32'hA0 + c - 1);
        end
      end
    end
    wait_ready();
    avs_write = 1'b1; avs_address = ADDR_W'(12); avs_writedata = 32'hD0D0_0000;
    avs_byteenable = 4'hF; avs_burstcount = 7'd2;
    step();
    avs_address = ADDR_W'(0); avs_writedata = 32'hD1D1_0001; avs_burstcount = 7'd1;
    step();
    bus_idle();
    rd_word(ADDR_W'(12), d, lat);
    tests++;
    if (d !== 32'hD0D0_0000) begin
      fails++; $display("FAIL burst_wr_12: got %h, need d0d00000", d);
    end
    rd_word(ADDR_W'(13), d, lat);
    tests++;
    if (d !== 32'hD1D1_0001) begin
      fails++; $display("FAIL burst_wr_13: got %h, need d1d10001", d);
    end
  endtask
`endif

  initial begin
    reset_reset_n = 1'b0;
    bus_idle();
`ifdef PCIE_BAR_RESP_BURST_EN
    avs_burstcount = 7'd1;
`endif
    test_reset();
    test_scratch();
    test_doorbell();
`ifndef PCIE_BAR_RESP_BURST_EN
    test_ram_back_to_back();
`else
    apply_reset();
    for (int i = 0; i < 4; i++) wr_word(ADDR_W'(8 + i), 32'hA0 + i, 4'hF);
`endif
    test_write_then_read();
    test_bad_addr();
    test_collision();
    test_reset_flush();
`ifdef PCIE_BAR_RESP_BURST_EN
    test_burst();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
